// File: rtl/count_seq_ctrl.sv
// Start/stop/pause sequence counter with up/down sweep, optional auto-reload
// and a saturating terminal-event counter.
module count_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int EVW   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic [WIDTH-1:0] cfg_limit,
  input  logic             cfg_down,
  input  logic             cfg_reload,
  output logic [WIDTH-1:0] count,
  output logic [1:0]       state,
  output logic             busy,
  output logic             done,
  output logic             tc_pulse,
  output logic [EVW-1:0]   ev_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_nxt;
  logic [WIDTH-1:0] count_q, count_nxt;
  logic [WIDTH-1:0] lim_q, lim_nxt;
  logic             down_q, down_nxt;
  logic             reload_q, reload_nxt;
  logic             tc_q, tc_nxt;
  logic [EVW-1:0]   ev_q, ev_nxt;
  logic             start_ok;
  logic             terminal;

  function automatic logic [EVW-1:0] sat_inc(input logic [EVW-1:0] v);
    return (&v) ? v : v + EVW'(1);
  endfunction

  // First value of a sweep: 0 counting up, the limit counting down.
  function automatic logic [WIDTH-1:0] sweep_start(input logic dn,
                                                   input logic [WIDTH-1:0] lim);
    return dn ? lim : '0;
  endfunction

  assign start_ok = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign terminal = down_q ? (count_q == '0) : (count_q == lim_q);

  always_comb begin
    state_nxt  = state_q;
    count_nxt  = count_q;
    lim_nxt    = lim_q;
    down_nxt   = down_q;
    reload_nxt = reload_q;
    tc_nxt     = 1'b0;
    ev_nxt     = ev_q;
    if (stop) begin
      state_nxt = S_IDLE;
      count_nxt = '0;
    end else if (start_ok) begin
      lim_nxt    = cfg_limit;
      down_nxt   = cfg_down;
      reload_nxt = cfg_reload;
      count_nxt  = sweep_start(cfg_down, cfg_limit);
      ev_nxt     = '0;
      state_nxt  = S_RUN;
    end else begin
      case (state_q)
        S_RUN: begin
          if (pause) begin
            state_nxt = S_PAUSE;
          end else if (terminal) begin
            tc_nxt = 1'b1;
            ev_nxt = sat_inc(ev_q);
            if (reload_q) count_nxt = sweep_start(down_q, lim_q);
            else          state_nxt = S_DONE;
          end else if (down_q) begin
            count_nxt = count_q - WIDTH'(1);
          end else begin
            count_nxt = count_q + WIDTH'(1);
          end
        end
        S_PAUSE: begin
          if (!pause) state_nxt = S_RUN;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q  <= '0;
      lim_q    <= '0;
      down_q   <= 1'b0;
      reload_q <= 1'b0;
      tc_q     <= 1'b0;
      ev_q     <= '0;
    end else begin
      count_q  <= count_nxt;
      lim_q    <= lim_nxt;
      down_q   <= down_nxt;
      reload_q <= reload_nxt;
      tc_q     <= tc_nxt;
      ev_q     <= ev_nxt;
    end
  end

  assign count    = count_q;
  assign state    = state_q;
  assign busy     = (state_q == S_RUN) || (state_q == S_PAUSE);
  assign done     = (state_q == S_DONE);
  assign tc_pulse = tc_q;
  assign ev_cnt   = ev_q;

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Bench for count_seq_ctrl: directed sequences with literal expectations plus
// a per-cycle comparison against a behavioural model.
module tb_count_seq_ctrl;

  localparam int WIDTH  = 4;
  localparam int EVW    = 8;
  localparam int EV_MAX = (1 << EVW) - 1;

  logic             clk;
  logic             reset;
  logic             start, stop, pause;
  logic [WIDTH-1:0] cfg_limit;
  logic             cfg_down, cfg_reload;
  logic [WIDTH-1:0] count;
  logic [1:0]       state;
  logic             busy, done, tc_pulse;
  logic [EVW-1:0]   ev_cnt;

  int vectors     = 0;
  int miscompares = 0;

  // Behavioural model state (IDLE=0 RUN=1 PAUSE=2 DONE=3)
  int m_state = 0, m_count = 0, m_ev = 0, m_tc = 0;
  int m_lim = 0, m_dn = 0, m_rl = 0;

  count_seq_ctrl #(.WIDTH(WIDTH), .EVW(EVW)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .pause(pause),
    .cfg_limit(cfg_limit), .cfg_down(cfg_down), .cfg_reload(cfg_reload),
    .count(count), .state(state), .busy(busy), .done(done),
    .tc_pulse(tc_pulse), .ev_cnt(ev_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_state = 0; m_count = 0; m_ev = 0; m_tc = 0;
      m_lim = 0; m_dn = 0; m_rl = 0;
    end else begin
      int sweep_begin, sweep_end;
      m_tc = 0;
      if (stop) begin
        m_state = 0;
        m_count = 0;
      end else if (start && (m_state == 0 || m_state == 3)) begin
        m_lim   = int'(cfg_limit);
        m_dn    = int'(cfg_down);
        m_rl    = int'(cfg_reload);
        m_count = m_dn ? m_lim : 0;
        m_ev    = 0;
        m_state = 1;
      end else if (m_state == 1) begin
        sweep_begin = m_dn ? m_lim : 0;
        sweep_end   = m_dn ? 0 : m_lim;
        if (pause) begin
          m_state = 2;
        end else if (m_count == sweep_end) begin
          m_tc = 1;
          m_ev = (m_ev + 1 > EV_MAX) ? EV_MAX : m_ev + 1;
          if (m_rl != 0) m_count = sweep_begin;
          else           m_state = 3;
        end else begin
          m_count = m_count + (m_dn ? -1 : 1);
        end
      end else if (m_state == 2) begin
        if (!pause) m_state = 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("count", int'(count), m_count);
    chk("state", int'(state), m_state);
    chk("busy", int'(busy), (m_state == 1 || m_state == 2) ? 1 : 0);
    chk("done", int'(done), (m_state == 3) ? 1 : 0);
    chk("tc_pulse", int'(tc_pulse), m_tc);
    chk("ev_cnt", int'(ev_cnt), m_ev);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic sp, input logic pa);
    start = st;
    stop  = sp;
    pause = pa;
    tick();
  endtask

  task automatic cfg(input int lim, input logic dn, input logic rl);
    cfg_limit  = WIDTH'(lim);
    cfg_down   = dn;
    cfg_reload = rl;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_count"}, int'(count), 0);
    chk({tag, "_state"}, int'(state), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_tc"}, int'(tc_pulse), 0);
    chk({tag, "_ev"}, int'(ev_cnt), 0);
  endtask

  initial begin
    int seq3[12];
    seq3 = '{3, 2, 1, 0, 3, 2, 1, 0, 3, 2, 1, 0};
    start = 1'b0; stop = 1'b0; pause = 1'b0;
    cfg(0, 1'b0, 1'b0);
    reset = 1'b1;
    #1 reset = 1'b0;
    #2 chk_all_zero("reset");
    tick();
    reset = 1'b1;

    // Up count to 5, no reload
    cfg(5, 1'b0, 1'b0);
    drive(1, 0, 0);
    chk("up5_first", int'(count), 0);
    chk("up5_state", int'(state), 1);
    for (int k = 1; k <= 5; k++) begin
      drive(0, 0, 0);
      chk("up5_count", int'(count), k);
      chk("up5_tc_low", int'(tc_pulse), 0);
    end
    drive(0, 0, 0);
    chk("up5_tc", int'(tc_pulse), 1);
    chk("up5_done_state", int'(state), 3);
    chk("up5_hold", int'(count), 5);
    chk("up5_ev", int'(ev_cnt), 1);
    cfg(2, 1'b1, 1'b1);
    drive(0, 0, 0);
    chk("up5_tc_once", int'(tc_pulse), 0);
    chk("up5_done_hold", int'(state), 3);
    chk("up5_count_hold", int'(count), 5);

    // Down from 3 with reload, started out of DONE
    cfg(3, 1'b1, 1'b1);
    drive(1, 0, 0);
    chk("dn3_count", int'(count), seq3[0]);
    chk("dn3_ev_clr", int'(ev_cnt), 0);
    for (int k = 1; k < 12; k++) begin
      drive(0, 0, 0);
      chk("dn3_count", int'(count), seq3[k]);
      chk("dn3_tc", int'(tc_pulse), (k % 4 == 0) ? 1 : 0);
    end
    chk("dn3_ev_mid", int'(ev_cnt), 2);
    drive(0, 0, 0);
    chk("dn3_tc_last", int'(tc_pulse), 1);
    chk("dn3_ev", int'(ev_cnt), 3);
    chk("dn3_reload", int'(count), 3);
    cfg(7, 1'b0, 1'b0);
    drive(1, 0, 0);
    chk("run_start_ignored", int'(count), 2);
    chk("run_start_ev", int'(ev_cnt), 3);
    drive(0, 1, 0);
    chk("dn3_stop_state", int'(state), 0);
    chk("dn3_stop_count", int'(count), 0);
    chk("dn3_stop_ev", int'(ev_cnt), 3);

    // Up to 9 with a 3-cycle pause at 4; limit change mid-run is ignored
    cfg(9, 1'b0, 1'b0);
    drive(1, 0, 0);
    for (int k = 1; k <= 4; k++) drive(0, 0, 0);
    chk("p9_at4", int'(count), 4);
    cfg(2, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 1);
      chk("p9_pstate", int'(state), 2);
      chk("p9_phold", int'(count), 4);
      chk("p9_busy", int'(busy), 1);
    end
    drive(0, 0, 0);
    chk("p9_resume_state", int'(state), 1);
    chk("p9_resume_count", int'(count), 4);
    for (int k = 5; k <= 9; k++) begin
      drive(0, 0, 0);
      chk("p9_count", int'(count), k);
    end
    drive(0, 0, 0);
    chk("p9_done", int'(state), 3);
    chk("p9_tc", int'(tc_pulse), 1);

    // Start+stop together, then stop mid-run at 6
    drive(0, 1, 0);
    cfg(15, 1'b0, 1'b0);
    drive(1, 1, 0);
    chk("ss_state", int'(state), 0);
    chk("ss_count", int'(count), 0);
    drive(1, 0, 0);
    for (int k = 1; k <= 6; k++) drive(0, 0, 0);
    chk("st6_count", int'(count), 6);
    drive(0, 1, 0);
    chk("st6_state", int'(state), 0);
    chk("st6_count0", int'(count), 0);
    chk("st6_tc", int'(tc_pulse), 0);

    // Limit 0 with reload: terminal every cycle, ev_cnt saturates
    cfg(0, 1'b0, 1'b1);
    drive(1, 0, 0);
    chk("z_first_tc", int'(tc_pulse), 0);
    for (int k = 1; k <= 300; k++) begin
      drive(0, 0, 0);
      chk("z_tc", int'(tc_pulse), 1);
      chk("z_count", int'(count), 0);
      if (k == 200) chk("z_ev200", int'(ev_cnt), 200);
    end
    chk("z_ev_sat", int'(ev_cnt), 255);
    chk("z_state", int'(state), 1);

    // Asynchronous reset mid-run at 7
    drive(0, 1, 0);
    cfg(15, 1'b0, 1'b0);
    drive(1, 0, 0);
    for (int k = 1; k <= 7; k++) drive(0, 0, 0);
    chk("ar_at7", int'(count), 7);
    #2 reset = 1'b0;
    #1 chk_all_zero("async_rst");
    start = 1'b1;
    tick();
    chk_all_zero("rst_held");
    reset = 1'b1;
    drive(0, 0, 0);
    chk("post_rst_idle", int'(state), 0);
    drive(1, 0, 0);
    chk("post_rst_run", int'(state), 1);
    chk("post_rst_count", int'(count), 0);
    drive(0, 0, 0);
    chk("post_rst_inc", int'(count), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
